// File: rtl/speed_ramp_pkg.sv
// Shared definitions for the speed setpoint ramp: state encoding and default step/limit values.
package speed_ramp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam logic [15:0] DEF_STOP_STEP = 16'd64;
  localparam logic [15:0] DEF_VMAX      = 16'd16384;

endpackage

// File: rtl/speed_ramp_axis.sv
// One wheel's slew register: on tick, moves cur toward tgt by at most step; otherwise holds.
// at_target reports whether the value registered at the coming edge equals tgt.
module speed_ramp_axis #(
  parameter int unsigned W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic signed [W-1:0] tgt,
  input  logic        [W-1:0] step,
  output logic signed [W-1:0] cur,
  output logic                at_target
);

  logic signed [W-1:0] cur_q, cur_d;
  logic signed [W:0]   cur_x, tgt_x, diff, mag, step_x, nxt;

  always_comb begin
    cur_x  = {cur_q[W-1], cur_q};
    tgt_x  = {tgt[W-1], tgt};
    diff   = tgt_x - cur_x;
    mag    = diff[W] ? -diff : diff;
    step_x = {1'b0, step};
    // One extra bit keeps diff exact; the stepped result never passes tgt, so it fits W bits.
    nxt    = diff[W] ? (cur_x - step_x) : (cur_x + step_x);
    cur_d  = cur_q;
    if (tick) begin
      cur_d = ($unsigned(mag) <= $unsigned(step_x)) ? tgt : nxt[W-1:0];
    end
    at_target = (cur_d == tgt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign cur = cur_q;

endmodule

// File: rtl/speed_ramp.sv
// Setpoint shaper ahead of the speed PID: slews both wheel setpoints toward accepted targets once per ramp tick.
// Optional SPEED_RAMP_SAT_EN clamps accepted targets to +/-VMAX; ready drops during STOP or while stop_i is high.
module speed_ramp
  import speed_ramp_pkg::*;
#(
  parameter int unsigned        CLK_FREQ  = 100_000_000,
  parameter int unsigned        RAMP_FREQ = 1000,
  parameter int unsigned        PID_RES   = 16,
  parameter logic [PID_RES-1:0] STOP_STEP = PID_RES'(DEF_STOP_STEP)
`ifdef SPEED_RAMP_SAT_EN
  ,
  parameter logic [PID_RES-1:0] VMAX      = PID_RES'(DEF_VMAX)
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic                      target_valid_i,
  output logic                      target_ready_o,
  input  logic signed [PID_RES-1:0] targetL_i,
  input  logic signed [PID_RES-1:0] targetR_i,
  input  logic        [PID_RES-1:0] accel_i,
  input  logic                      stop_i,
  output logic signed [PID_RES-1:0] speedL_o,
  output logic signed [PID_RES-1:0] speedR_o,
  output logic                      tick_o,
  output logic                      busy_o
);

  localparam int unsigned TICK_N = CLK_FREQ / RAMP_FREQ;
  localparam int unsigned CNT_W  = (TICK_N > 1) ? $clog2(TICK_N) : 1;

  logic                      srst, tick, ready, accept, at_l, at_r;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  state_e                    state_q, state_d;
  logic signed [PID_RES-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic signed [PID_RES-1:0] in_l, in_r, cur_l, cur_r;
  logic        [PID_RES-1:0] step;

`ifdef SPEED_RAMP_SAT_EN
  function automatic logic signed [PID_RES-1:0] sat(input logic signed [PID_RES-1:0] x);
    logic signed [PID_RES:0] lim, neg_lim, xe;
    lim     = $signed({1'b0, VMAX});
    neg_lim = -lim;
    xe      = $signed({x[PID_RES-1], x});
    if (xe > lim)     return lim[PID_RES-1:0];
    if (xe < neg_lim) return neg_lim[PID_RES-1:0];
    return x;
  endfunction
`endif

  always_comb begin
    srst   = rst | clr;
    tick   = en && !srst && (cnt_q == CNT_W'(TICK_N - 1));
    cnt_d  = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
    ready  = !srst && (state_q != ST_STOP) && !stop_i;
    accept = target_valid_i && ready;
    step   = (state_q == ST_STOP) ? STOP_STEP : accel_i;
`ifdef SPEED_RAMP_SAT_EN
    in_l   = sat(targetL_i);
    in_r   = sat(targetR_i);
`else
    in_l   = targetL_i;
    in_r   = targetR_i;
`endif

    state_d = state_q;
    tgt_l_d = tgt_l_q;
    tgt_r_d = tgt_r_q;
    case (state_q)
      ST_IDLE, ST_RAMP: begin
        if (stop_i) begin
          state_d = ST_STOP;
          tgt_l_d = '0;
          tgt_r_d = '0;
        end else if (accept) begin
          // A mid-ramp accept only swaps targets; the slew continues from the current speed.
          tgt_l_d = in_l;
          tgt_r_d = in_r;
          if ((state_q == ST_IDLE) && ((in_l != cur_l) || (in_r != cur_r))) begin
            state_d = ST_RAMP;
          end
        end else if ((state_q == ST_RAMP) && at_l && at_r) begin
          state_d = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (at_l && at_r && !stop_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      tgt_l_q <= '0;
      tgt_r_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tgt_l_q <= tgt_l_d;
      tgt_r_q <= tgt_r_d;
    end
  end

  speed_ramp_axis #(.W(PID_RES)) u_axis_l (
    .clk       (clk),
    .rst       (srst),
    .tick      (tick),
    .tgt       (tgt_l_q),
    .step      (step),
    .cur       (cur_l),
    .at_target (at_l)
  );

  speed_ramp_axis #(.W(PID_RES)) u_axis_r (
    .clk       (clk),
    .rst       (srst),
    .tick      (tick),
    .tgt       (tgt_r_q),
    .step      (step),
    .cur       (cur_r),
    .at_target (at_r)
  );

  assign target_ready_o = ready;
  assign speedL_o       = cur_l;
  assign speedR_o       = cur_r;
  assign tick_o         = tick;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_speed_ramp.sv
// Bench for speed_ramp: directed ramp/stop/retarget/enable scenarios plus randomized traffic against a reference model.
module tb_speed_ramp;

  localparam int N     = 10;
  localparam int SSTEP = 50;
  localparam int VMAXV = 1000;

  logic        clk = 1'b0;
  logic        rst, clr, en, target_valid_i, stop_i;
  logic [15:0] targetL_i, targetR_i, accel_i;
  logic        target_ready_o, tick_o, busy_o;
  logic [15:0] speedL_o, speedR_o;

  int errors = 0;
  int checks = 0;

  // Reference state: speeds, targets, tick counter, mode 0=idle 1=ramp 2=stop
  int m_l, m_r, m_tl, m_tr, m_cnt, m_mode;
  bit m_tick, m_ready, m_busy;
  int n_cyc;

  always #5 clk = ~clk;

  speed_ramp #(
    .CLK_FREQ  (100),
    .RAMP_FREQ (10),
    .PID_RES   (16),
    .STOP_STEP (16'd50)
`ifdef SPEED_RAMP_SAT_EN
    ,
    .VMAX      (16'd1000)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .en             (en),
    .target_valid_i (target_valid_i),
    .target_ready_o (target_ready_o),
    .targetL_i      (targetL_i),
    .targetR_i      (targetR_i),
    .accel_i        (accel_i),
    .stop_i         (stop_i),
    .speedL_o       (speedL_o),
    .speedR_o       (speedR_o),
    .tick_o         (tick_o),
    .busy_o         (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int approach(input int c, input int t, input int s);
    int d;
    d = t - c;
    if (d <= s && d >= -s) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  function automatic int clamp_tgt(input int t);
`ifdef SPEED_RAMP_SAT_EN
    if (t > VMAXV) return VMAXV;
    if (t < -VMAXV) return -VMAXV;
`endif
    return t;
  endfunction

  task automatic model_reset();
    m_l = 0; m_r = 0; m_tl = 0; m_tr = 0; m_cnt = 0; m_mode = 0;
  endtask

  task automatic model_outputs();
    bit s;
    s       = rst || clr;
    m_ready = !s && (m_mode != 2) && !stop_i;
    m_tick  = !s && en && (m_cnt == N - 1);
    m_busy  = (m_mode != 0);
  endtask

  task automatic model_next();
    int nl, nr, st;
    bit acc;
    if (rst || clr) begin
      model_reset();
      return;
    end
    nl = m_l;
    nr = m_r;
    if (m_tick) begin
      st = (m_mode == 2) ? SSTEP : int'(accel_i);
      nl = approach(m_l, m_tl, st);
      nr = approach(m_r, m_tr, st);
    end
    if (en) m_cnt = m_tick ? 0 : m_cnt + 1;
    acc = target_valid_i && m_ready;
    if (m_mode != 2 && stop_i) begin
      m_mode = 2; m_tl = 0; m_tr = 0;
    end else if (acc) begin
      m_tl = clamp_tgt(int'($signed(targetL_i)));
      m_tr = clamp_tgt(int'($signed(targetR_i)));
      if (m_mode == 0 && (m_tl != nl || m_tr != nr)) m_mode = 1;
    end else if (m_mode == 1 && nl == m_tl && nr == m_tr) begin
      m_mode = 0;
    end else if (m_mode == 2 && nl == 0 && nr == 0 && !stop_i) begin
      m_mode = 0;
    end
    m_l = nl;
    m_r = nr;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step_cycle();
    #1;
    model_outputs();
    check("cycle", {speedL_o, speedR_o, tick_o, busy_o, target_ready_o},
                   {16'(m_l), 16'(m_r), m_tick, m_busy, m_ready});
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_tick(output int n);
    for (int i = 1; i <= 3 * N; i++) begin
      step_cycle();
      if (m_tick) begin
        n = i;
        return;
      end
    end
    n = -1;
    check("tick_timeout", 0, 1);
  endtask

  task automatic chk_spd(input string tag, input int l, input int r);
    check(tag, {speedL_o, speedR_o}, {16'(l), 16'(r)});
  endtask

  task automatic offer(input int l, input int r);
    target_valid_i = 1'b1;
    targetL_i = 16'(l);
    targetR_i = 16'(r);
    step_cycle();
    target_valid_i = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step_cycle();
    clr = 1'b0;
  endtask

  // Clear, then ramp toward 1000 with accel 100 until both speeds reach 200.
  task automatic ramp_to_200();
    do_clr();
    accel_i = 16'd100;
    offer(1000, 1000);
    run_to_tick(n_cyc);
    run_to_tick(n_cyc);
    chk_spd("pre_200", 200, 200);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b1; target_valid_i = 1'b0; stop_i = 1'b0;
    targetL_i = '0; targetR_i = '0; accel_i = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    step_cycle();
    step_cycle();
    check("rst_speed", {speedL_o, speedR_o}, 32'd0);
    check("rst_flags", {tick_o, busy_o, target_ready_o}, 3'b000);
    rst = 1'b0;
    #1;
    check("ready_after_rst", target_ready_o, 1'b1);

    // Ramp to 250/-250 in steps of 100
    accel_i = 16'd100;
    offer(250, -250);
    run_to_tick(n_cyc);
    chk_spd("ramp_t1", 100, -100);
    run_to_tick(n_cyc);
    chk_spd("ramp_t2", 200, -200);
    run_to_tick(n_cyc);
    chk_spd("ramp_t3", 250, -250);
    check("ramp_done_busy", busy_o, 1'b0);

    // Emergency stop pulse with a same-cycle target that must be dropped
    ramp_to_200();
    stop_i = 1'b1;
    target_valid_i = 1'b1;
    targetL_i = 16'd500;
    targetR_i = 16'd500;
    #1;
    check("stop_ready_low", target_ready_o, 1'b0);
    step_cycle();
    stop_i = 1'b0;
    target_valid_i = 1'b0;
    check("stop_busy", busy_o, 1'b1);
    run_to_tick(n_cyc);
    chk_spd("stop_t1", 150, 150);
    run_to_tick(n_cyc);
    chk_spd("stop_t2", 100, 100);
    run_to_tick(n_cyc);
    chk_spd("stop_t3", 50, 50);
    run_to_tick(n_cyc);
    chk_spd("stop_t4", 0, 0);
    check("stop_exit", {busy_o, target_ready_o}, 2'b01);
    run_to_tick(n_cyc);
    chk_spd("stop_dropped", 0, 0);

    // Retarget to 0 between ticks: continue from 200 without restarting
    ramp_to_200();
    step_cycle();
    offer(0, 0);
    run_to_tick(n_cyc);
    chk_spd("retgt_t1", 100, 100);
    run_to_tick(n_cyc);
    chk_spd("retgt_t2", 0, 0);
    check("retgt_idle", busy_o, 1'b0);

    // Enable held low mid-ramp
    ramp_to_200();
    en = 1'b0;
    repeat (30) step_cycle();
    chk_spd("en_hold", 200, 200);
    en = 1'b1;
    run_to_tick(n_cyc);
    check("en_resume_cycles", 32'(n_cyc), 32'(N));
    chk_spd("en_resume", 300, 300);

    // Extreme targets with a step larger than the full range
    do_clr();
    accel_i = 16'd40000;
    offer(-32768, 5000);
    run_to_tick(n_cyc);
`ifdef SPEED_RAMP_SAT_EN
    chk_spd("wide_t1", -1000, 1000);
`else
    chk_spd("wide_t1", -32768, 5000);
`endif
    offer(32767, -32768);
    run_to_tick(n_cyc);
`ifdef SPEED_RAMP_SAT_EN
    chk_spd("wide_t2", 1000, -1000);
`else
    chk_spd("wide_t2", 7232, -32768);
`endif

    // Randomized traffic against the model
    do_clr();
    for (int i = 0; i < 3000; i++) begin
      target_valid_i = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 3) == 0) begin
        targetL_i = 16'($urandom);
        targetR_i = 16'($urandom);
      end else begin
        targetL_i = 16'($urandom_range(0, 4000) - 2000);
        targetR_i = 16'($urandom_range(0, 4000) - 2000);
      end
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 9))
          0:       accel_i = 16'd0;
          1:       accel_i = 16'($urandom);
          default: accel_i = 16'($urandom_range(1, 400));
        endcase
      end
      if ($urandom_range(0, 99) < 3) stop_i = ~stop_i;
      en  = ($urandom_range(0, 99) < 92);
      clr = ($urandom_range(0, 999) < 3);
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
